// File: rtl/tok_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tok_encoder
//  Purpose  : Streams a zero-terminated string from an input SRAM, splits it
//             into words on a programmable separator, looks each word up in a
//             fixed-stride vocabulary SRAM and emits one token per word on a
//             valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module tok_encoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int IN_ADDR_WIDTH  = 8,
  parameter int VOCAB_ENTRIES  = 16,
  parameter int MAX_WORD_LEN   = 8,
  parameter int TOK_WIDTH      = 5,
  parameter int VOC_ADDR_WIDTH = $clog2(VOCAB_ENTRIES*MAX_WORD_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic [IN_ADDR_WIDTH-1:0]  in_base,
  input  logic [DATA_WIDTH-1:0]     sep,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic [VOC_ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0]     voc_data,
  output logic                      tok_valid,
  input  logic                      tok_ready,
  output logic [TOK_WIDTH-1:0]      tok_data,
  output logic                      busy,
  output logic                      done,
  output logic [IN_ADDR_WIDTH-1:0]  tok_count
);

  localparam int LEN_W = $clog2(MAX_WORD_LEN + 1);
  localparam int POS_W = (MAX_WORD_LEN > 1) ? $clog2(MAX_WORD_LEN) : 1;
  localparam int ENT_W = (VOCAB_ENTRIES > 1) ? $clog2(VOCAB_ENTRIES) : 1;

  localparam logic [TOK_WIDTH-1:0]     UNK_ID   = {TOK_WIDTH{1'b1}};
  localparam logic [IN_ADDR_WIDTH-1:0] IN_LAST  = {IN_ADDR_WIDTH{1'b1}};
  localparam logic [ENT_W-1:0]         LAST_ENT = ENT_W'(VOCAB_ENTRIES - 1);
  localparam logic [POS_W-1:0]         LAST_POS = POS_W'(MAX_WORD_LEN - 1);
  localparam logic [LEN_W-1:0]         LEN_MAX  = LEN_W'(MAX_WORD_LEN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEARCH = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t state, state_nx;

  // Run context
  logic [DATA_WIDTH-1:0]    sep_q;
  logic [IN_ADDR_WIDTH-1:0] cur_addr;   // address of the character in in_data
  logic                     rd_vld;     // in_data holds a requested character
  logic                     wrap;       // past the top address: virtual terminator
  logic                     end_flag;   // current word was closed by the terminator

  // Word buffer
  logic [DATA_WIDTH-1:0]    word_buf [MAX_WORD_LEN];
  logic [LEN_W-1:0]         len;
  logic                     ovf;

  // Vocabulary scan
  logic [ENT_W-1:0]         ent;
  logic [POS_W-1:0]         pos;        // position of the byte in voc_data
  logic                     srch_vld;   // voc_data holds a requested byte

  // Decode
  logic [DATA_WIDTH-1:0]    ch;
  logic                     ch_vld, is_term, is_sep, is_char, word_close;
  logic [DATA_WIDTH-1:0]    cmp_char;
  logic                     cmp_eq, hit, miss_last, handshake;

  // Classify the current input character and the current vocabulary compare
  always_comb begin
    ch         = wrap ? '0 : in_data;
    ch_vld     = (state == FETCH) && (rd_vld || wrap);
    is_term    = ch_vld && (ch == '0);
    is_sep     = ch_vld && !is_term && (ch == sep_q);
    is_char    = ch_vld && !is_term && !is_sep;
    word_close = (is_term || is_sep) && (len != '0);
    cmp_char   = (LEN_W'(pos) < len) ? word_buf[pos] : '0;
    cmp_eq     = (cmp_char == voc_data);
    hit        = (state == SEARCH) && srch_vld && cmp_eq && (pos == LAST_POS);
    miss_last  = (state == SEARCH) && srch_vld && !cmp_eq && (ent == LAST_ENT);
    handshake  = (state == EMIT) && tok_valid && tok_ready;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs) state_nx = FETCH;
      FETCH: begin
        if (is_term && (len == '0)) state_nx = FINISH;
        else if (word_close)        state_nx = ovf ? EMIT : SEARCH;
      end
      SEARCH:  if (hit || miss_last) state_nx = EMIT;
      EMIT:    if (handshake) state_nx = end_flag ? FINISH : FETCH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath: address generation, word capture, vocabulary scan and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_addr   <= '0;
      voc_addr  <= '0;
      tok_valid <= 1'b0;
      tok_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tok_count <= '0;
      sep_q     <= '0;
      cur_addr  <= '0;
      rd_vld    <= 1'b0;
      wrap      <= 1'b0;
      end_flag  <= 1'b0;
      len       <= '0;
      ovf       <= 1'b0;
      ent       <= '0;
      pos       <= '0;
      srch_vld  <= 1'b0;
      for (int i = 0; i < MAX_WORD_LEN; i++) word_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cs) begin
            in_addr   <= in_base;
            sep_q     <= sep;
            tok_count <= '0;
            len       <= '0;
            ovf       <= 1'b0;
            end_flag  <= 1'b0;
            wrap      <= 1'b0;
            rd_vld    <= 1'b0;
            busy      <= 1'b1;
            for (int i = 0; i < MAX_WORD_LEN; i++) word_buf[i] <= '0;
          end
        end

        FETCH: begin
          // Keep one read in flight; a closing word rewinds to the next address.
          in_addr  <= in_addr + IN_ADDR_WIDTH'(1);
          cur_addr <= in_addr;
          rd_vld   <= 1'b1;
          if (rd_vld && !wrap && (cur_addr == IN_LAST)) wrap <= 1'b1;
          if (is_char) begin
            if (len == LEN_MAX) begin
              ovf <= 1'b1;
            end else begin
              word_buf[POS_W'(len)] <= ch;
              len <= len + LEN_W'(1);
            end
          end
          if (is_term && (len == '0)) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          if (word_close) begin
            in_addr  <= cur_addr + IN_ADDR_WIDTH'(1);
            rd_vld   <= 1'b0;
            end_flag <= is_term;
            if (ovf) begin
              tok_data  <= UNK_ID;
              tok_valid <= 1'b1;
            end else begin
              ent      <= '0;
              pos      <= '0;
              srch_vld <= 1'b0;
              voc_addr <= '0;
            end
          end
        end

        SEARCH: begin
          if (!srch_vld) begin
            srch_vld <= 1'b1;
            voc_addr <= voc_addr + VOC_ADDR_WIDTH'(1);
          end else if (cmp_eq) begin
            if (pos == LAST_POS) begin
              tok_data  <= TOK_WIDTH'(ent);
              tok_valid <= 1'b1;
            end else begin
              pos      <= pos + POS_W'(1);
              voc_addr <= voc_addr + VOC_ADDR_WIDTH'(1);
            end
          end else if (ent == LAST_ENT) begin
            tok_data  <= UNK_ID;
            tok_valid <= 1'b1;
          end else begin
            // Abandon this entry and restart at the next one's first byte.
            ent      <= ent + ENT_W'(1);
            pos      <= '0;
            srch_vld <= 1'b0;
            voc_addr <= VOC_ADDR_WIDTH'((int'(ent) + 1) * MAX_WORD_LEN);
          end
        end

        EMIT: begin
          if (handshake) begin
            tok_valid <= 1'b0;
            if (tok_count != IN_LAST) tok_count <= tok_count + IN_ADDR_WIDTH'(1);
            len <= '0;
            ovf <= 1'b0;
            for (int i = 0; i < MAX_WORD_LEN; i++) word_buf[i] <= '0;
            if (end_flag) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
        end

        FINISH: begin
        end

        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tok_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tok_encoder
//  Purpose  : Self-checking bench for tok_encoder against a string-level
//             reference model of word splitting and vocabulary lookup.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tok_encoder;

  localparam int AW  = 8;
  localparam int NE  = 16;
  localparam int ML  = 8;
  localparam int TW  = 5;
  localparam int VW  = $clog2(NE*ML);
  localparam int UNK = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic [AW-1:0] in_base = '0;
  logic [7:0]    sep = 8'h20;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic [VW-1:0] voc_addr;
  logic [7:0]    voc_data;
  logic          tok_valid;
  logic          tok_ready = 1'b1;
  logic [TW-1:0] tok_data;
  logic          busy, done;
  logic [AW-1:0] tok_count;

  always #5 clk = ~clk;

  logic [7:0] in_mem  [256];
  logic [7:0] voc_mem [NE*ML];

  // Synchronous SRAM models: data valid one cycle after the address
  always @(posedge clk) begin
    in_data  <= in_mem[in_addr];
    voc_data <= voc_mem[voc_addr];
  end

  tok_encoder #(
    .DATA_WIDTH(8), .IN_ADDR_WIDTH(AW), .VOCAB_ENTRIES(NE),
    .MAX_WORD_LEN(ML), .TOK_WIDTH(TW), .VOC_ADDR_WIDTH(VW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .in_base(in_base), .sep(sep),
    .in_addr(in_addr), .in_data(in_data), .voc_addr(voc_addr), .voc_data(voc_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
    .busy(busy), .done(done), .tok_count(tok_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  string voc_words [NE] = '{"hi", "cat", "dog", "", "catastro", "cat", "a", "to",
                            "go", "", "tac", "odd", "hit", "sad", "ac", "gig"};
  string pool [20] = '{"hi", "cat", "dog", "catastro", "a", "to", "go", "tac", "odd", "hit",
                       "sad", "ac", "gig", "cow", "ca", "catastrophe", "h", "dogs",
                       "catastrop", "t"};

  task automatic put_str(input int base, input string s, input bit term);
    for (int i = 0; i < s.len(); i++) in_mem[(base + i) % 256] = s[i];
    if (term) in_mem[(base + s.len()) % 256] = 8'h00;
  endtask

  // Reference model: split the string held in in_mem into words and look
  // each one up; also derive when the first token should appear.
  int exp_q[$];
  int exp_first;

  task automatic model(input int base, input logic [7:0] sepc);
    logic [7:0] word[$];
    logic [7:0] c, wc;
    int a, n, cost, tok, p;
    bit stop, same;
    exp_q.delete();
    exp_first = -1;
    word.delete();
    a = base; n = 0; stop = 0;
    while (!stop) begin
      c = (a > 255) ? 8'h00 : in_mem[a];
      a++; n++;
      if (c == 8'h00 || c == sepc) begin
        if (word.size() > 0) begin
          tok = UNK; cost = 0;
          if (word.size() <= ML) begin
            for (int e = 0; e < NE && tok == UNK; e++) begin
              same = 1; p = 0;
              for (int k = 0; k < ML && same; k++) begin
                wc = (k < word.size()) ? word[k] : 8'h00;
                p++;
                if (wc != voc_mem[e*ML + k]) same = 0;
              end
              cost += p + 1;
              if (same) tok = e;
            end
          end
          exp_q.push_back(tok);
          if (exp_first < 0) exp_first = 1 + n + cost;
          word.delete();
        end
        if (c == 8'h00) stop = 1;
      end else begin
        word.push_back(c);
      end
    end
  endtask

  // One run: mode 0 ready high, 1 random ready, 2 ready low 5 cycles per token
  task automatic run(input int base, input logic [7:0] sepc, input int mode,
                     input bit extra_cs, input string tag);
    int got[$];
    int cyc, wait_cnt, first_seen, done_cyc;
    bit fin, pend;
    logic [TW-1:0] held;
    model(base, sepc);
    @(negedge clk);
    cs = 1'b1; in_base = AW'(base); sep = sepc;
    @(negedge clk);
    cs = 1'b0;
    chk({tag, ":busy_rise"}, busy, 1);
    cyc = 0; wait_cnt = 0; first_seen = -1; done_cyc = -1; fin = 0; pend = 0; held = '0;
    while (!fin && cyc < 4000) begin
      cs = extra_cs && (cyc == 3);
      if (extra_cs && cyc == 3) begin
        in_base = 8'd200;
        sep     = 8'h61;
      end
      case (mode)
        1:       tok_ready = 1'($urandom_range(0, 1));
        2:       tok_ready = tok_valid && (wait_cnt >= 5);
        default: tok_ready = 1'b1;
      endcase
      if (pend) begin
        chk({tag, ":hold_valid"}, tok_valid, 1);
        chk({tag, ":hold_data"}, tok_data, held);
      end
      if (tok_valid && first_seen < 0) first_seen = cyc;
      if (tok_valid && tok_ready) begin
        got.push_back(int'(tok_data));
        pend = 0; wait_cnt = 0;
      end else if (tok_valid) begin
        pend = 1; held = tok_data; wait_cnt++;
      end else begin
        pend = 0;
      end
      if (done) begin
        fin = 1; done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    cs = 1'b0;
    if (!fin) chk({tag, ":timeout"}, 0, 1);
    chk({tag, ":ntok"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s:tok%0d", tag, i), got[i], exp_q[i]);
    chk({tag, ":tok_count"}, tok_count, exp_q.size());
    if (exp_q.size() > 0) chk({tag, ":first_lat"}, first_seen, exp_first);
    else                  chk({tag, ":done_within4"}, (done_cyc >= 0 && done_cyc <= 4), 1);
    @(negedge clk);
    chk({tag, ":done_once"}, done, 0);
    chk({tag, ":busy_fall"}, busy, 0);
    tok_ready = 1'b1;
  endtask

  // Hang guard
  initial begin
    #900000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int k, base, nw;
    string s, sp;
    logic [7:0] sc;

    for (int i = 0; i < 256; i++) in_mem[i] = 8'h00;
    for (int e = 0; e < NE; e++)
      for (int j = 0; j < ML; j++)
        voc_mem[e*ML + j] = (j < voc_words[e].len()) ? voc_words[e][j] : 8'h00;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst:in_addr",   in_addr, 0);
    chk("rst:voc_addr",  voc_addr, 0);
    chk("rst:tok_valid", tok_valid, 0);
    chk("rst:tok_data",  tok_data, 0);
    chk("rst:busy",      busy, 0);
    chk("rst:done",      done, 0);
    chk("rst:tok_count", tok_count, 0);
    rst_n = 1'b1;

    put_str(0, "cat dog", 1);          run(0, 8'h20, 0, 0, "basic");
    put_str(20, "  cat   cow hi", 1);  run(20, 8'h20, 0, 0, "seps_unk");
    put_str(40, "dog hi", 1);          run(40, 8'h20, 2, 0, "backpressure");
    put_str(60, "catastrophe", 1);     run(60, 8'h20, 0, 0, "overflow");
    put_str(80, "ca", 1);              run(80, 8'h20, 0, 0, "prefix");
    put_str(90, "catastro gig", 1);    run(90, 8'h20, 0, 0, "fullwidth_last");
    put_str(105, "", 1);               run(105, 8'h20, 0, 0, "empty");
    put_str(200, "gig hit", 1);
    put_str(110, "hi dog a to", 1);    run(110, 8'h20, 0, 1, "cs_while_busy");
    put_str(252, "cat ", 0);           run(252, 8'h20, 0, 0, "wrap_sep");
    put_str(253, "dog", 0);            run(253, 8'h20, 0, 0, "wrap_word");

    // Asynchronous reset while a token is pending
    put_str(10, "dog hi", 1);
    @(negedge clk);
    cs = 1'b1; in_base = 8'd10; sep = 8'h20; tok_ready = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    k = 0;
    while (!tok_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid:valid_before", tok_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid:tok_valid", tok_valid, 0);
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:done", done, 0);
    @(negedge clk);
    chk("rst_mid:no_done", done, 0);
    rst_n = 1'b1;
    tok_ready = 1'b1;
    put_str(30, "hi", 1);              run(30, 8'h20, 0, 0, "post_rst");

    // Randomised strings, separators and backpressure
    for (int r = 0; r < 24; r++) begin
      sc = ($urandom_range(0, 3) == 0) ? 8'h2C : 8'h20;
      sp = (sc == 8'h2C) ? "," : " ";
      s  = "";
      nw = $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) s = {s, sp};
      for (int w = 0; w < nw; w++) begin
        s = {s, pool[$urandom_range(0, 19)]};
        repeat ($urandom_range(1, 3)) s = {s, sp};
      end
      base = $urandom_range(0, 250 - s.len());
      put_str(base, s, 1);
      run(base, sc, $urandom_range(0, 1), 0, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
